mem_io_responder: RTL and testbench

//   Responder end of the byte-serial CPU memory bus driven by the cache controller.

---
 rtl/mem_io_responder_pkg.sv | 36 +++
 rtl/mem_io_responder_byte_fifo.sv | 57 +++++
 rtl/mem_io_responder.sv | 107 ++++++++++
 tb/tb_mem_io_responder.sv | 219 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_io_responder_pkg.sv
// Shared constants, bus decode record and helpers for the memory/IO responder.
package mem_io_responder_pkg;

  localparam int unsigned BYTE = 8;
  localparam int unsigned IO_OFFSET_WIDTH = 3;

  localparam logic [IO_OFFSET_WIDTH-1:0] IO_TX_RX_OFFSET       = 3'd0;
  localparam logic [IO_OFFSET_WIDTH-1:0] IO_STATUS_HALT_OFFSET = 3'd4;

  localparam logic RW_READ  = 1'b1;
  localparam logic RW_WRITE = 1'b0;

  // One decoded bus transfer, qualified by readyIn.
  typedef struct packed {
    logic                       rdEn;
    logic                       wrEn;
    logic                       isIo;
    logic [IO_OFFSET_WIDTH-1:0] ioOffset;
  } busReq_t;

  function automatic busReq_t decodeBus(input logic ready, input logic readWrite,
                                        input logic ioSel,
                                        input logic [IO_OFFSET_WIDTH-1:0] offset);
    busReq_t req;
    req.rdEn     = ready & (readWrite == RW_READ);
    req.wrEn     = ready & (readWrite == RW_WRITE);
    req.isIo     = ioSel;
    req.ioOffset = offset;
    return req;
  endfunction

  function automatic logic [BYTE-1:0] statusByte(input logic rxNonEmpty, input logic txFull);
    return {(BYTE-2)'(0), rxNonEmpty, txFull};
  endfunction

endpackage

// File: rtl/mem_io_responder_byte_fifo.sv
// Byte FIFO with wrap-bit pointers and registered full/empty flags.
module byte_fifo
  import mem_io_responder_pkg::*;
#(
  parameter int unsigned DEPTH_WIDTH = 4
) (
  input  logic            clkIn,
  input  logic            resetIn,
  input  logic            push,
  input  logic            pop,
  input  logic [BYTE-1:0] dataIn,
  output logic [BYTE-1:0] dataOut,
  output logic            full,
  output logic            empty
);

  localparam int unsigned DEPTH = 1 << DEPTH_WIDTH;
  localparam int unsigned PTR_W = DEPTH_WIDTH + 1;

  logic [BYTE-1:0]  mem [DEPTH];
  logic [PTR_W-1:0] wrPtr, rdPtr;
  logic [PTR_W-1:0] wrPtrNext, rdPtrNext;
  logic             pushEff, popEff;
  logic             fullNext, emptyNext;

  // Pop on empty is dropped; push on full only lands when a pop frees the slot.
  always_comb begin
    popEff    = pop & ~empty;
    pushEff   = push & (~full | popEff);
    wrPtrNext = pushEff ? wrPtr + PTR_W'(1) : wrPtr;
    rdPtrNext = popEff  ? rdPtr + PTR_W'(1) : rdPtr;
    emptyNext = (wrPtrNext == rdPtrNext);
    fullNext  = (wrPtrNext[DEPTH_WIDTH-1:0] == rdPtrNext[DEPTH_WIDTH-1:0]) &&
                (wrPtrNext[DEPTH_WIDTH] != rdPtrNext[DEPTH_WIDTH]);
  end

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      wrPtr <= '0;
      rdPtr <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else begin
      wrPtr <= wrPtrNext;
      rdPtr <= rdPtrNext;
      full  <= fullNext;
      empty <= emptyNext;
    end
  end

  always_ff @(posedge clkIn) begin
    if (pushEff && resetIn) mem[wrPtr[DEPTH_WIDTH-1:0]] <= dataIn;
  end

  assign dataOut = mem[rdPtr[DEPTH_WIDTH-1:0]];

endmodule

// File: rtl/mem_io_responder.sv
// Byte-serial bus responder: on-chip RAM plus an IO window with UART TX/RX FIFOs,
// status byte and sticky halt flag.
module mem_io_responder
  import mem_io_responder_pkg::*;
#(
  parameter int unsigned ADDR_WIDTH = 18,
  parameter int unsigned RAM_WIDTH  = 17,
  parameter int unsigned FIFO_WIDTH = 4
) (
  input  logic                  clkIn,
  input  logic                  resetIn,
  input  logic                  readyIn,
  input  logic                  readWriteIn,
  input  logic [ADDR_WIDTH-1:0] memAddrIn,
  input  logic [BYTE-1:0]       memDataIn,
  output logic [BYTE-1:0]       memDataOut,
  output logic                  ioFull,
  output logic [BYTE-1:0]       txData,
  output logic                  txValid,
  input  logic                  txReady,
  input  logic [BYTE-1:0]       rxData,
  input  logic                  rxValid,
  output logic                  rxReady,
  output logic                  haltOut
);

  localparam int unsigned RAM_DEPTH = 1 << RAM_WIDTH;

  logic [BYTE-1:0]      ram [RAM_DEPTH];
  logic [RAM_WIDTH-1:0] ramAddr;
  busReq_t              req;

  logic            ramWe;
  logic            txPush, txPop, txFull, txEmpty;
  logic            rxPush, rxPop, rxFull, rxEmpty;
  logic [BYTE-1:0] rxHead;
  logic [BYTE-1:0] ioReadData;
  logic            haltSet;
  logic            ioTxRx, ioStatus;

  assign req     = decodeBus(readyIn, readWriteIn, memAddrIn[ADDR_WIDTH-1],
                             memAddrIn[IO_OFFSET_WIDTH-1:0]);
  assign ramAddr = memAddrIn[RAM_WIDTH-1:0];

  // IO window decode and FIFO handshakes on both sides.
  always_comb begin
    ioTxRx   = req.isIo && (req.ioOffset == IO_TX_RX_OFFSET);
    ioStatus = req.isIo && (req.ioOffset == IO_STATUS_HALT_OFFSET);
    ramWe    = req.wrEn & ~req.isIo & resetIn;
    txPush   = req.wrEn & ioTxRx;
    rxPop    = req.rdEn & ioTxRx;
    haltSet  = req.wrEn & ioStatus;
    txPop    = ~txEmpty & txReady;
    rxPush   = rxValid & ~rxFull;
  end

  always_comb begin
    ioReadData = '0;
    if (ioTxRx && !rxEmpty) ioReadData = rxHead;
    else if (ioStatus)      ioReadData = statusByte(~rxEmpty, txFull);
  end

  always_ff @(posedge clkIn) begin
    if (ramWe) ram[ramAddr] <= memDataIn;
  end

  // Read data is loaded only on a qualified read; otherwise it holds.
  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn) begin
      memDataOut <= '0;
    end else if (req.rdEn) begin
      memDataOut <= req.isIo ? ioReadData : ram[ramAddr];
    end
  end

  always_ff @(posedge clkIn or negedge resetIn) begin
    if (!resetIn)     haltOut <= 1'b0;
    else if (haltSet) haltOut <= 1'b1;
  end

  byte_fifo #(.DEPTH_WIDTH(FIFO_WIDTH)) uTxFifo (
    .clkIn   (clkIn),
    .resetIn (resetIn),
    .push    (txPush),
    .pop     (txPop),
    .dataIn  (memDataIn),
    .dataOut (txData),
    .full    (txFull),
    .empty   (txEmpty)
  );

  byte_fifo #(.DEPTH_WIDTH(FIFO_WIDTH)) uRxFifo (
    .clkIn   (clkIn),
    .resetIn (resetIn),
    .push    (rxPush),
    .pop     (rxPop),
    .dataIn  (rxData),
    .dataOut (rxHead),
    .full    (rxFull),
    .empty   (rxEmpty)
  );

  assign ioFull  = txFull;
  assign txValid = ~txEmpty;
  assign rxReady = ~rxFull;

endmodule

// File: tb/tb_mem_io_responder.sv
// Directed and randomized bench for mem_io_responder against a queue-based model.
module tb_mem_io_responder;

  logic        clkIn = 1'b0;
  logic        resetIn;
  logic        readyIn, readWriteIn;
  logic [17:0] memAddrIn;
  logic [7:0]  memDataIn, memDataOut;
  logic        ioFull, txValid, txReady, rxValid, rxReady, haltOut;
  logic [7:0]  txData, rxData;

  mem_io_responder dut (
    .clkIn(clkIn), .resetIn(resetIn), .readyIn(readyIn), .readWriteIn(readWriteIn),
    .memAddrIn(memAddrIn), .memDataIn(memDataIn), .memDataOut(memDataOut),
    .ioFull(ioFull), .txData(txData), .txValid(txValid), .txReady(txReady),
    .rxData(rxData), .rxValid(rxValid), .rxReady(rxReady), .haltOut(haltOut)
  );

  always #5 clkIn = ~clkIn;

  int testCount = 0;
  int failCount = 0;

  // Reference model state
  bit [7:0] ramModel [int];
  bit [7:0] txQ [$];
  bit [7:0] rxQ [$];
  bit [7:0] expOut;
  bit       expKnown;
  bit       haltM;

  task automatic checkVal(input string tag, input logic [31:0] got, input logic [31:0] exp);
    testCount++;
    if (got !== exp) begin
      failCount++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic modelEdge();
    int  txSize0 = txQ.size();
    int  rxSize0 = rxQ.size();
    bit  txPop   = txReady && (txSize0 > 0);
    bit  rxPush  = rxValid && (rxSize0 < 16);
    bit  txPush  = 1'b0;
    bit  rxPop   = 1'b0;
    if (readyIn) begin
      if (!memAddrIn[17]) begin
        int idx = int'(memAddrIn[16:0]);
        if (readWriteIn) begin
          expKnown = ramModel.exists(idx);
          if (expKnown) expOut = ramModel[idx];
        end else begin
          ramModel[idx] = memDataIn;
        end
      end else begin
        case (memAddrIn[2:0])
          3'd0: if (readWriteIn) begin
                  expKnown = 1'b1;
                  if (rxSize0 > 0) begin expOut = rxQ[0]; rxPop = 1'b1; end
                  else expOut = 8'h00;
                end else begin
                  txPush = (txSize0 < 16) || txPop;
                end
          3'd4: if (readWriteIn) begin
                  expKnown = 1'b1;
                  expOut   = {6'b0, rxSize0 > 0, txSize0 == 16};
                end else begin
                  haltM = 1'b1;
                end
          default: if (readWriteIn) begin expKnown = 1'b1; expOut = 8'h00; end
        endcase
      end
    end
    if (txPop)  void'(txQ.pop_front());
    if (txPush) txQ.push_back(memDataIn);
    if (rxPop)  void'(rxQ.pop_front());
    if (rxPush) rxQ.push_back(rxData);
  endtask

  task automatic checkOutputs();
    if (expKnown) checkVal("memDataOut", memDataOut, expOut);
    checkVal("txValid", txValid, 32'(txQ.size() > 0));
    checkVal("ioFull",  ioFull,  32'(txQ.size() == 16));
    if (txQ.size() > 0) checkVal("txData", txData, txQ[0]);
    checkVal("rxReady", rxReady, 32'(rxQ.size() < 16));
    checkVal("haltOut", haltOut, haltM);
  endtask

  // One clock: drive inputs, step the model on the edge, check 1 time unit later.
  task automatic busCycle(input logic rdy, input logic rw, input logic [17:0] addr,
                          input logic [7:0] wdata, input logic txr, input logic rxv,
                          input logic [7:0] rxd);
    readyIn = rdy; readWriteIn = rw; memAddrIn = addr; memDataIn = wdata;
    txReady = txr; rxValid = rxv; rxData = rxd;
    @(posedge clkIn);
    modelEdge();
    #1;
    checkOutputs();
  endtask

  // Asynchronous reset asserted between edges; effect must be immediate.
  task automatic midCycleReset();
    #2 resetIn = 1'b0;
    #1;
    txQ.delete(); rxQ.delete();
    haltM = 1'b0; expOut = 8'h00; expKnown = 1'b1;
    checkVal("rst_haltOut",    haltOut,    0);
    checkVal("rst_txValid",    txValid,    0);
    checkVal("rst_ioFull",     ioFull,     0);
    checkVal("rst_rxReady",    rxReady,    1);
    checkVal("rst_memDataOut", memDataOut, 0);
    readyIn = 1'b0; rxValid = 1'b0; txReady = 1'b0;
    @(negedge clkIn);
    @(negedge clkIn);
    resetIn = 1'b1;
  endtask

  initial begin
    int drained;
    resetIn = 1'b0; readyIn = 1'b0; readWriteIn = 1'b1; memAddrIn = '0; memDataIn = '0;
    txReady = 1'b0; rxValid = 1'b0; rxData = '0;
    expOut = 8'h00; expKnown = 1'b1; haltM = 1'b0;
    repeat (3) @(negedge clkIn);
    resetIn = 1'b1;

    // 1: reset state
    checkVal("t1_memDataOut", memDataOut, 0);
    checkVal("t1_txValid",    txValid,    0);
    checkVal("t1_rxReady",    rxReady,    1);
    checkVal("t1_haltOut",    haltOut,    0);
    busCycle(0, 1, 18'h0, 8'h0, 0, 0, 8'h0);

    // 2: write then back-to-back read
    busCycle(1, 0, 18'h00010, 8'hA5, 0, 0, 8'h0);
    busCycle(1, 1, 18'h00010, 8'h00, 0, 0, 8'h0);
    checkVal("t2_readback", memDataOut, 8'hA5);

    // 3: fill TX FIFO past full, then drain
    for (int i = 1; i <= 17; i++) begin
      busCycle(1, 0, 18'h30000, 8'h41, 0, 0, 8'h0);
      if (i == 15) checkVal("t3_notFull15", ioFull, 0);
      if (i == 16) checkVal("t3_full16",    ioFull, 1);
    end
    checkVal("t3_full17", ioFull, 1);
    drained = 0;
    for (int i = 0; i < 40 && txValid; i++) begin
      if (txData == 8'h41) drained++;
      busCycle(0, 1, 18'h0, 8'h0, 1, 0, 8'h0);
    end
    checkVal("t3_drainCount", drained, 16);
    checkVal("t3_txEmpty",    txValid, 0);

    // 4: RX empty read, UART push, status, pop
    busCycle(1, 1, 18'h30000, 8'h0, 0, 0, 8'h0);
    checkVal("t4_emptyRead", memDataOut, 8'h00);
    busCycle(0, 1, 18'h0, 8'h0, 0, 1, 8'h5A);
    busCycle(1, 1, 18'h30004, 8'h0, 0, 0, 8'h0);
    checkVal("t4_status", memDataOut, 8'h02);
    busCycle(1, 1, 18'h30000, 8'h0, 0, 0, 8'h0);
    checkVal("t4_rxPop", memDataOut, 8'h5A);
    busCycle(1, 1, 18'h30004, 8'h0, 0, 0, 8'h0);
    checkVal("t4_statusEmpty", memDataOut, 8'h00);

    // 5: frozen bus ignores a write and holds read data
    busCycle(1, 0, 18'h00020, 8'h77, 0, 0, 8'h0);
    busCycle(1, 1, 18'h00010, 8'h00, 0, 0, 8'h0);
    busCycle(0, 0, 18'h00020, 8'h99, 0, 0, 8'h0);
    checkVal("t5_hold", memDataOut, 8'hA5);
    busCycle(1, 1, 18'h00020, 8'h00, 0, 0, 8'h0);
    checkVal("t5_ramKept", memDataOut, 8'h77);

    // 6: sticky halt, then reset mid-burst
    busCycle(1, 0, 18'h30004, 8'h00, 0, 0, 8'h0);
    checkVal("t6_halt", haltOut, 1);
    busCycle(0, 1, 18'h0, 8'h0, 0, 0, 8'h0);
    busCycle(1, 0, 18'h00030, 8'h00, 0, 0, 8'h0);
    checkVal("t6_haltSticky", haltOut, 1);
    busCycle(1, 0, 18'h30000, 8'h11, 0, 1, 8'h22);
    busCycle(1, 0, 18'h30000, 8'h33, 0, 1, 8'h44);
    midCycleReset();
    busCycle(1, 1, 18'h00010, 8'h00, 0, 0, 8'h0);
    checkVal("t6_ramSurvives", memDataOut, 8'hA5);

    // Randomized traffic in phases that alternately fill and drain the FIFOs
    for (int i = 0; i < 3000; i++) begin
      logic        rdy, rw, txr, rxv;
      logic [17:0] addr;
      int          kind;
      bit          fillPhase = ((i / 400) % 2) == 0;
      rdy  = ($urandom_range(0, 9) != 0);
      rw   = $urandom_range(0, 1) != 0;
      txr  = $urandom_range(0, 99) < (fillPhase ? 10 : 85);
      rxv  = $urandom_range(0, 99) < (fillPhase ? 80 : 15);
      kind = $urandom_range(0, 9);
      if (kind < 4) begin
        addr = (kind == 0) ? {1'b0, 12'hFFF, 5'($urandom_range(0, 31))}
                           : 18'($urandom_range(0, 63));
      end else begin
        logic [2:0] off;
        off  = (kind < 7) ? 3'd0 : ((kind < 9) ? 3'd4 : 3'($urandom_range(0, 7)));
        if (off == 3'd4 && !rw && $urandom_range(0, 7) != 0) rw = 1'b1;
        addr = {1'b1, 14'($urandom), off};
      end
      busCycle(rdy, rw, addr, 8'($urandom), txr, rxv, 8'($urandom));
      if (i == 1500) midCycleReset();
    end

    $display("[TB] %0d tests run, %0d failed", testCount, failCount);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
